// File: rtl/qam16_coherent_demodulator.sv
// rtl/qam16_coherent_demodulator.sv - 16-QAM coherent integrate-and-dump demodulator with Gray slicer
module qam16_coherent_demodulator #(
  parameter int DATA_W = 16,
  parameter int SPS = 1024,
  parameter int ACC_W = 48,
  parameter logic signed [ACC_W-1:0] THRESH = ACC_W'(64'h40_0000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] rf_in,
  input  logic signed [DATA_W-1:0] lo_sin,
  input  logic signed [DATA_W-1:0] lo_cos,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic [3:0]               symbol,
  output logic signed [ACC_W-1:0]  i_soft,
  output logic signed [ACC_W-1:0]  q_soft,
  output logic                     overrun,
  output logic                     busy
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic signed [ACC_W-1:0] NEG_THRESH = -THRESH;

  typedef enum logic [1:0] {IDLE, ACQ, DUMP} state_t;

  state_t state_q, state_d;
  logic signed [ACC_W-1:0] p_i_q, p_q_q;
  logic p_valid_q, p_valid_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sym_valid_q, overrun_q;
  logic [3:0] symbol_q;
  logic signed [ACC_W-1:0] i_soft_q, q_soft_q;
  logic signed [2*DATA_W-1:0] prod_i, prod_q;
  logic abort, dump, xfer;

  assign prod_i = $signed((2*DATA_W)'(rf_in)) * $signed((2*DATA_W)'(lo_cos));
  assign prod_q = $signed((2*DATA_W)'(rf_in)) * $signed((2*DATA_W)'(lo_sin));

  // stop only matters once acquisition is running; it also overrides a dump
  assign abort = stop && (state_q != IDLE);
  assign dump  = (state_q == DUMP) && !abort;
  assign xfer  = sym_valid_q && sym_ready;

  assign p_valid_d = sample_valid && (state_q != IDLE) && !abort;

  // Per-axis decision: outer negative 00, inner negative 01, inner positive 11, outer positive 10
  function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] a);
    if (a < NEG_THRESH)   slice = 2'b00;
    else if (a[ACC_W-1])  slice = 2'b01;
    else if (a < THRESH)  slice = 2'b11;
    else                  slice = 2'b10;
  endfunction

  // Mixer stage: product registers load on every valid sample, even in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_i_q     <= '0;
      p_q_q     <= '0;
      p_valid_q <= 1'b0;
    end else begin
      p_valid_q <= p_valid_d;
      if (sample_valid) begin
        p_i_q <= ACC_W'(prod_i);
        p_q_q <= ACC_W'(prod_q);
      end
    end
  end

  // Control state and integrator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: integrate in ACQ, dump for one cycle while reloading the sample in flight
  always_comb begin
    state_d = state_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
        if (start) state_d = ACQ;
      end
      ACQ: begin
        if (p_valid_q) begin
          acc_i_d = acc_i_q + p_i_q;
          acc_q_d = acc_q_q + p_q_q;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DUMP;
        end
      end
      DUMP: begin
        acc_i_d = p_valid_q ? p_i_q : '0;
        acc_q_d = p_valid_q ? p_q_q : '0;
        cnt_d   = p_valid_q ? CNT_W'(1) : '0;
        state_d = ACQ;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end
  end

  // Output slot: a dump loads a new symbol, overwriting an unaccepted one flags overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_valid_q <= 1'b0;
      symbol_q    <= '0;
      i_soft_q    <= '0;
      q_soft_q    <= '0;
      overrun_q   <= 1'b0;
    end else if (dump) begin
      sym_valid_q <= 1'b1;
      symbol_q    <= {slice(acc_i_q), slice(acc_q_q)};
      i_soft_q    <= acc_i_q;
      q_soft_q    <= acc_q_q;
      if (sym_valid_q && !sym_ready) overrun_q <= 1'b1;
    end else if (xfer) begin
      sym_valid_q <= 1'b0;
    end
  end

  assign sym_valid = sym_valid_q;
  assign symbol    = symbol_q;
  assign i_soft    = i_soft_q;
  assign q_soft    = q_soft_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qam16_coherent_demodulator.sv
// tb/tb_qam16_coherent_demodulator.sv - scoreboard bench for qam16_coherent_demodulator
module tb_qam16_coherent_demodulator;

  localparam int  SPS = 4;
  localparam longint T = 64'd536870912;

  logic clk = 1'b0;
  logic rst, start, stop, sample_valid, sym_ready;
  logic signed [15:0] rf_in, lo_sin, lo_cos;
  logic sym_valid, overrun, busy;
  logic [3:0] symbol;
  logic signed [47:0] i_soft, q_soft;

  qam16_coherent_demodulator #(
    .DATA_W(16), .SPS(SPS), .ACC_W(48), .THRESH(48'sd536870912)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .rf_in(rf_in), .lo_sin(lo_sin), .lo_cos(lo_cos),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .symbol(symbol),
    .i_soft(i_soft), .q_soft(q_soft), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sym;
    longint     i;
    longint     q;
  } exp_t;

  exp_t   sbq[$];
  exp_t   last_exp;
  int     total = 0;
  int     bad = 0;
  int     pops = 0;
  int     vcyc = 0;
  bit     m_active = 0;
  bit     push_en = 1;
  longint m_si = 0, m_sq = 0;
  int     m_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_slice(input longint v);
    if (v < -T) return 2'b00;
    if (v < 0)  return 2'b01;
    if (v < T)  return 2'b11;
    return 2'b10;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample per call; the reference groups every SPS samples seen while running
  task automatic drive_sample(input int rf, input int s, input int c);
    exp_t e;
    sample_valid = 1'b1;
    rf_in  = rf[15:0];
    lo_sin = s[15:0];
    lo_cos = c[15:0];
    tick();
    sample_valid = 1'b0;
    if (m_active) begin
      m_si += longint'(rf) * longint'(c);
      m_sq += longint'(rf) * longint'(s);
      m_cnt++;
      if (m_cnt == SPS) begin
        e.sym = {ref_slice(m_si), ref_slice(m_sq)};
        e.i = m_si;
        e.q = m_sq;
        last_exp = e;
        if (push_en) sbq.push_back(e);
        m_si = 0; m_sq = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!m_active) begin
      m_active = 1; m_si = 0; m_sq = 0; m_cnt = 0;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_active = 0; m_si = 0; m_sq = 0; m_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, "_valid"}, sym_valid, 1);
    chk({name, "_sym"}, symbol, e.sym);
    chk({name, "_i"}, longint'(i_soft), e.i);
    chk({name, "_q"}, longint'(q_soft), e.q);
  endtask

  // Monitor: every accepted symbol is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (sym_valid) vcyc++;
      if (sym_valid && sym_ready) begin
        pops++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_symbol: got %b expected none", symbol);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("mon_sym", symbol, e.sym);
          chk("mon_i", longint'(i_soft), e.i);
          chk("mon_q", longint'(q_soft), e.q);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t a;
    int p0, v0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0; sym_ready = 1'b0;
    rf_in = '0; lo_sin = '0; lo_cos = '0;
    #1;
    chk("rst_valid", sym_valid, 0);
    chk("rst_sym", symbol, 0);
    chk("rst_i", longint'(i_soft), 0);
    chk("rst_q", longint'(q_soft), 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic symbol and latency, held with sym_ready low
    do_start();
    chk("busy_acq", busy, 1);
    for (int k = 0; k < 4; k++) drive_sample(16384, 0, 16384);
    @(negedge clk);
    chk("lat_n0", sym_valid, 0);
    tick();
    chk("lat_n1", sym_valid, 0);
    tick();
    chk("lat_n2", sym_valid, 1);
    chk("t1_sym", symbol, 4'b1011);
    chk("t1_i", longint'(i_soft), 64'd1073741824);
    chk("t1_q", longint'(q_soft), 0);
    idle(3);
    chk("t1_hold_sym", symbol, 4'b1011);
    chk("t1_hold_i", longint'(i_soft), 64'd1073741824);
    sym_ready = 1'b1;
    idle(4);

    // Slicer regions and exact boundaries
    for (int k = 0; k < 4; k++) drive_sample(-16384, -16384, 0);
    idle(3);
    for (int k = 0; k < 4; k++) drive_sample(4096, -16384, 0);
    idle(3);
    drive_sample(16384, 0, 16384); drive_sample(16384, 0, 16384);
    drive_sample(-16384, 0, 16384); drive_sample(-16384, 0, 16384);
    idle(3);
    drive_sample(-16384, 0, 16384); drive_sample(-16384, 0, 16384);
    drive_sample(0, 0, 0); drive_sample(0, 0, 0);
    idle(3);
    drive_sample(16384, -16384, 16384); drive_sample(16384, -16384, 16384);
    drive_sample(0, 0, 0); drive_sample(0, 0, 0);
    idle(3);
    for (int k = 0; k < 3; k++) drive_sample(-16384, 0, 16384);
    drive_sample(0, 0, 0);
    idle(4);

    // Back-to-back samples across a symbol boundary
    p0 = pops; v0 = vcyc;
    for (int k = 0; k < 8; k++) drive_sample(rnd16(), rnd16(), rnd16());
    idle(6);
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_valid_cycles", vcyc - v0, 2);
    chk("b2b_overrun", overrun, 0);

    // Random symbols with random gaps
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < SPS; k++) begin
        drive_sample(rnd16(), rnd16(), rnd16());
        idle($urandom_range(2));
      end
    end
    idle(4);

    // Dump coinciding with a transfer: no overrun
    sym_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());
    idle(3);
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());
    tick();
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("coinc_overrun", overrun, 0);
    check_out("coinc_new", last_exp);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    idle(2);

    // Overwrite of an unaccepted symbol
    push_en = 0;
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());
    idle(2);
    a = last_exp;
    check_out("ovr_a", a);
    idle(3);
    check_out("ovr_a_hold", a);
    push_en = 1;
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());
    check_out("ovr_a_late", a);
    chk("ovr_before", overrun, 0);
    idle(3);
    chk("ovr_after", overrun, 1);
    check_out("ovr_b", last_exp);
    sym_ready = 1'b1;
    idle(3);

    // stop mid-symbol, restart, and start ignored while acquiring
    drive_sample(32767, 32767, 32767);
    drive_sample(32767, 32767, 32767);
    do_stop();
    chk("stop_busy", busy, 0);
    idle(2);
    do_start();
    drive_sample(rnd16(), rnd16(), rnd16());
    drive_sample(rnd16(), rnd16(), rnd16());
    do_start();
    drive_sample(rnd16(), rnd16(), rnd16());
    drive_sample(rnd16(), rnd16(), rnd16());
    idle(4);

    // Asynchronous reset mid-symbol with a symbol pending
    sym_ready = 1'b0;
    push_en = 0;
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());
    idle(3);
    chk("pre_rst_valid", sym_valid, 1);
    drive_sample(rnd16(), rnd16(), rnd16());
    drive_sample(rnd16(), rnd16(), rnd16());
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", sym_valid, 0);
    chk("arst_sym", symbol, 0);
    chk("arst_i", longint'(i_soft), 0);
    chk("arst_q", longint'(q_soft), 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_busy", busy, 0);
    m_active = 0; m_si = 0; m_sq = 0; m_cnt = 0;
    idle(2);
    rst = 1'b0;
    push_en = 1;
    sym_ready = 1'b1;
    idle(1);
    do_start();
    for (int k = 0; k < 4; k++) drive_sample(rnd16(), rnd16(), rnd16());

    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    chk("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
